// File: rtl/io_port_pkg.sv
// Shared constants and state encoding for the mini_CPU character I/O port.
// Imported by the port top and its output FIFO.
package io_port_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic {
        IN_EMPTY = 1'b0,
        IN_FULL  = 1'b1
    } in_state_t;

endpackage

// File: rtl/io_sync_fifo.sv
// Single-clock byte FIFO with unregistered head output (head visible the cycle after the write).
// Push while full and pop while empty are ignored.
module io_sync_fifo
    import io_port_pkg::*;
#(
    parameter int W     = DATA_W_DEF,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count_reg == FULL_COUNT);
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign dout    = mem[rd_ptr_reg];

    // Storage carries no reset: occupancy is defined by the pointers alone.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + (AW + 1)'(1);
                2'b01:   count_reg <= count_reg - (AW + 1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/io_char_port.sv
// Character I/O port: INPR holding register with FGI, OUTR FIFO with FGO/overflow,
// interrupt enable and request, and the last-delivered-byte register d_out.
module io_char_port
    import io_port_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int OUT_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inp_rd,
    output logic [DATA_W-1:0] inpr,
    output logic              fgi,
    input  logic              out_wr,
    input  logic [DATA_W-1:0] outr_in,
    output logic              fgo,
    output logic              out_ovf,
    input  logic              ien_set,
    input  logic              ien_clr,
    output logic              ien,
    output logic              irq,
    input  logic              dev_in_valid,
    input  logic [DATA_W-1:0] dev_in_data,
    output logic              dev_in_ready,
    output logic              dev_out_valid,
    output logic [DATA_W-1:0] dev_out_data,
    input  logic              dev_out_ready,
    output logic [DATA_W-1:0] d_out
);

    localparam int CW = $clog2(OUT_DEPTH) + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(OUT_DEPTH);

    in_state_t         state_reg;
    in_state_t         state_next;
    logic [DATA_W-1:0] inpr_reg;
    logic [DATA_W-1:0] inpr_next;
    logic              ovf_reg;
    logic              ien_reg;
    logic [DATA_W-1:0] d_out_reg;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic              pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IN_EMPTY;
            inpr_reg  <= '0;
        end else begin
            state_reg <= state_next;
            inpr_reg  <= inpr_next;
        end
    end

    // inpr keeps its last value after a read; only a new device byte replaces it.
    always_comb begin
        state_next = state_reg;
        inpr_next  = inpr_reg;
        case (state_reg)
            IN_EMPTY: begin
                if (dev_in_valid) begin
                    inpr_next  = dev_in_data;
                    state_next = IN_FULL;
                end
            end
            IN_FULL: begin
                if (inp_rd) begin
                    state_next = IN_EMPTY;
                end
            end
            default: state_next = IN_EMPTY;
        endcase
    end

    assign fgi          = (state_reg == IN_FULL);
    assign dev_in_ready = ~fgi;
    assign inpr         = inpr_reg;

    io_sync_fifo #(
        .W     (DATA_W),
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (out_wr),
        .din   (outr_in),
        .pop   (pop),
        .dout  (dev_out_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign fgo           = (fifo_count != FULL_COUNT);
    assign dev_out_valid = ~fifo_empty;
    assign pop           = dev_out_valid & dev_out_ready;

    // A full FIFO drops the OUT even if the device pops in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_reg   <= 1'b0;
            ien_reg   <= 1'b0;
            d_out_reg <= '0;
        end else begin
            if (out_wr && fifo_full) begin
                ovf_reg <= 1'b1;
            end
            if (ien_clr) begin
                ien_reg <= 1'b0;
            end else if (ien_set) begin
                ien_reg <= 1'b1;
            end
            if (pop) begin
                d_out_reg <= dev_out_data;
            end
        end
    end

    assign out_ovf = ovf_reg;
    assign ien     = ien_reg;
    assign irq     = ien_reg & (fgi | fgo);
    assign d_out   = d_out_reg;

endmodule
